mc_conflict_batcher: RTL and testbench



---
 rtl/conflict_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 55 +++++
 rtl/mc_conflict_batcher.sv | 228 ++++++++++++++++++++++
 tb/tb_mc_conflict_batcher.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conflict_pkg.sv
// Shared types for the multi-channel conflict batcher: batch FSM states,
// per-transaction conflict vector and the conflict-reduction helper.
package conflict_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CLOSE = 2'd2
    } batch_state_e;

    typedef struct packed {
        logic raw;
        logic waw;
        logic war;
    } conflict_t;

    // WAR only blocks admission when war_blocks is set; RAW/WAW always do.
    function automatic logic conflict_any(input conflict_t cv, input logic war_blocks);
        return cv.raw | cv.waw | (cv.war & war_blocks);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first valid at or after the pointer (wrapping);
// the pointer moves past the grant only when advance_i is high.
module rr_arbiter #(
    parameter  int NUM_CHANNELS = 4,
    localparam int SRC_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CHANNELS-1:0] valid_i,
    input  logic                    advance_i,
    output logic                    grant_valid_o,
    output logic [SRC_W-1:0]        grant_idx_o
);

    logic [SRC_W-1:0] ptr_q, ptr_d;
    logic             gnt_vld_s;
    logic [SRC_W-1:0] gnt_idx_s;

    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_CHANNELS) sum = sum - NUM_CHANNELS;
        return SRC_W'(sum);
    endfunction

    // Priority search starting at the pointer.
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!gnt_vld_s && valid_i[wrap_add(ptr_q, i)]) begin
                gnt_vld_s = 1'b1;
                gnt_idx_s = wrap_add(ptr_q, i);
            end else begin
                gnt_vld_s = gnt_vld_s;
            end
        end
    end

    // Pointer update: hold unless the grant was consumed.
    always_comb begin
        if (advance_i) ptr_d = wrap_add(gnt_idx_s, 1);
        else           ptr_d = ptr_q;
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign grant_valid_o = gnt_vld_s;
    assign grant_idx_o   = gnt_idx_s;

endmodule

// File: rtl/mc_conflict_batcher.sv
// Multi-channel conflict batcher: RR arbitration, RAW/WAW/WAR screening against the open
// batch and a batch-tagged output FIFO. Define CD_WAR_RELAX_EN to let WAR overlaps join a batch.
module mc_conflict_batcher
    import conflict_pkg::*;
#(
    parameter  int NUM_CHANNELS         = 4,
    parameter  int MAX_DEPENDENCIES     = 256,
    parameter  int MAX_BATCH_SIZE       = 8,
    parameter  int BATCH_TIMEOUT_CYCLES = 100,
    parameter  int FIFO_DEPTH           = 8,
    parameter  int BATCH_ID_W           = 8,
    localparam int SRC_W                = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int OCC_W                = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_CHANNELS-1:0]                  s_axis_tvalid,
    output logic [NUM_CHANNELS-1:0]                  s_axis_tready,
    input  logic [64*NUM_CHANNELS-1:0]               s_axis_tdata_owner_programID,
    input  logic [MAX_DEPENDENCIES*NUM_CHANNELS-1:0] s_axis_tdata_read_dependencies,
    input  logic [MAX_DEPENDENCIES*NUM_CHANNELS-1:0] s_axis_tdata_write_dependencies,
    output logic                                     m_axis_tvalid,
    input  logic                                     m_axis_tready,
    output logic [63:0]                              m_axis_tdata_owner_programID,
    output logic [MAX_DEPENDENCIES-1:0]              m_axis_tdata_read_dependencies,
    output logic [MAX_DEPENDENCIES-1:0]              m_axis_tdata_write_dependencies,
    output logic [BATCH_ID_W-1:0]                    m_axis_tdata_batch_id,
    output logic [SRC_W-1:0]                         m_axis_tdata_src_channel,
    output logic                                     batch_completed,
    output logic [31:0]                              raw_conflicts,
    output logic [31:0]                              waw_conflicts,
    output logic [31:0]                              war_conflicts,
    output logic [31:0]                              transactions_batched,
    output logic [31:0]                              batches_closed,
    output logic [OCC_W-1:0]                         fifo_occupancy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(MAX_BATCH_SIZE + 1);
    localparam int TMR_W = $clog2(BATCH_TIMEOUT_CYCLES);
`ifdef CD_WAR_RELAX_EN
    localparam logic WAR_BLOCKS = 1'b0;
`else
    localparam logic WAR_BLOCKS = 1'b1;
`endif

    typedef struct packed {
        logic [63:0]                 prog;
        logic [MAX_DEPENDENCIES-1:0] rd;
        logic [MAX_DEPENDENCIES-1:0] wr;
        logic [BATCH_ID_W-1:0]       bid;
        logic [SRC_W-1:0]            src;
    } fifo_entry_t;

    batch_state_e                state_q, state_d;
    logic [MAX_DEPENDENCIES-1:0] rmask_q, rmask_d, wmask_q, wmask_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [TMR_W-1:0]            timer_q, timer_d;
    logic [BATCH_ID_W-1:0]       bid_q, bid_d;
    logic [31:0]                 raw_q, raw_d, waw_q, waw_d, war_q, war_d;
    logic [31:0]                 txn_q, txn_d, closed_q, closed_d;
    logic                        done_q;
    fifo_entry_t                 mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]            occ_q, occ_d;

    logic                        gnt_vld_s, accept_s, pop_s, room_s, conflict_s, close_cfl_s;
    logic [SRC_W-1:0]            gnt_idx_s;
    logic [MAX_DEPENDENCIES-1:0] gnt_rd_s, gnt_wr_s;
    logic [63:0]                 gnt_prog_s;
    conflict_t                   cv_s;
    fifo_entry_t                 push_s;

    rr_arbiter #(.NUM_CHANNELS(NUM_CHANNELS)) u_arb (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_i       (s_axis_tvalid),
        .advance_i     (accept_s),
        .grant_valid_o (gnt_vld_s),
        .grant_idx_o   (gnt_idx_s)
    );

    // Granted channel's payload and its conflict terms against the open batch.
    always_comb begin
        gnt_prog_s  = s_axis_tdata_owner_programID[int'(gnt_idx_s)*64 +: 64];
        gnt_rd_s    = s_axis_tdata_read_dependencies[int'(gnt_idx_s)*MAX_DEPENDENCIES +: MAX_DEPENDENCIES];
        gnt_wr_s    = s_axis_tdata_write_dependencies[int'(gnt_idx_s)*MAX_DEPENDENCIES +: MAX_DEPENDENCIES];
        cv_s.raw    = |(gnt_rd_s & wmask_q);
        cv_s.waw    = |(gnt_wr_s & wmask_q);
        cv_s.war    = |(gnt_wr_s & rmask_q);
        conflict_s  = conflict_any(cv_s, WAR_BLOCKS);
        pop_s       = (occ_q != '0) && m_axis_tready;
        room_s      = (occ_q != OCC_W'(FIFO_DEPTH)) || pop_s;
        accept_s    = (state_q != ST_CLOSE) && gnt_vld_s && room_s && ((state_q == ST_IDLE) || !conflict_s);
        close_cfl_s = (state_q == ST_FILL) && gnt_vld_s && conflict_s && room_s;
        push_s      = '{prog: gnt_prog_s, rd: gnt_rd_s, wr: gnt_wr_s, bid: bid_q, src: gnt_idx_s};
    end

    // Only the granted channel can see ready, and only when it is taken this cycle.
    always_comb begin
        s_axis_tready = '0;
        if (accept_s) s_axis_tready[gnt_idx_s] = 1'b1;
        else          s_axis_tready = '0;
    end

    // Batch FSM: conflict beats size limit beats timeout when deciding to close.
    always_comb begin
        state_d  = state_q;
        rmask_d  = rmask_q;
        wmask_d  = wmask_q;
        count_d  = count_q;
        timer_d  = timer_q;
        bid_d    = bid_q;
        closed_d = closed_q;
        if (accept_s) begin
            rmask_d = rmask_q | gnt_rd_s;
            wmask_d = wmask_q | gnt_wr_s;
            count_d = count_q + CNT_W'(1);
            timer_d = '0;
        end else begin
            timer_d = timer_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = (MAX_BATCH_SIZE == 1) ? ST_CLOSE : ST_FILL;
                else          state_d = ST_IDLE;
            end
            ST_FILL: begin
                if (close_cfl_s)                                          state_d = ST_CLOSE;
                else if (accept_s)                                        state_d = (count_d == CNT_W'(MAX_BATCH_SIZE)) ? ST_CLOSE : ST_FILL;
                else if (timer_q == TMR_W'(BATCH_TIMEOUT_CYCLES - 1))     state_d = ST_CLOSE;
                else                                                      timer_d = timer_q + TMR_W'(1);
            end
            ST_CLOSE: begin
                state_d  = ST_IDLE;
                rmask_d  = '0;
                wmask_d  = '0;
                count_d  = '0;
                timer_d  = '0;
                bid_d    = bid_q + BATCH_ID_W'(1);
                closed_d = closed_q + 32'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Statistics; with WAR relaxed, WAR is tallied on transactions that were admitted anyway.
    always_comb begin
        raw_d = raw_q + {31'd0, close_cfl_s & cv_s.raw};
        waw_d = waw_q + {31'd0, close_cfl_s & cv_s.waw};
        war_d = war_q + {31'd0, (close_cfl_s & cv_s.war & WAR_BLOCKS) | (accept_s & cv_s.war & ~WAR_BLOCKS)};
        txn_d = txn_q + {31'd0, accept_s};
    end

    // FIFO pointer and occupancy bookkeeping; push and pop may coincide even when full.
    always_comb begin
        wr_ptr_d = accept_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_s    ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({accept_s, pop_s})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Control, statistics and FIFO pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rmask_q  <= '0;
            wmask_q  <= '0;
            count_q  <= '0;
            timer_q  <= '0;
            bid_q    <= '0;
            raw_q    <= '0;
            waw_q    <= '0;
            war_q    <= '0;
            txn_q    <= '0;
            closed_q <= '0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            state_q  <= state_d;
            rmask_q  <= rmask_d;
            wmask_q  <= wmask_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            bid_q    <= bid_d;
            raw_q    <= raw_d;
            waw_q    <= waw_d;
            war_q    <= war_d;
            txn_q    <= txn_d;
            closed_q <= closed_d;
            done_q   <= (state_d == ST_CLOSE);
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (accept_s) begin
            mem_q[wr_ptr_q] <= push_s;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign m_axis_tvalid                   = (occ_q != '0);
    assign m_axis_tdata_owner_programID    = mem_q[rd_ptr_q].prog;
    assign m_axis_tdata_read_dependencies  = mem_q[rd_ptr_q].rd;
    assign m_axis_tdata_write_dependencies = mem_q[rd_ptr_q].wr;
    assign m_axis_tdata_batch_id           = mem_q[rd_ptr_q].bid;
    assign m_axis_tdata_src_channel        = mem_q[rd_ptr_q].src;
    assign batch_completed                 = done_q;
    assign raw_conflicts                   = raw_q;
    assign waw_conflicts                   = waw_q;
    assign war_conflicts                   = war_q;
    assign transactions_batched            = txn_q;
    assign batches_closed                  = closed_q;
    assign fifo_occupancy                  = occ_q;

endmodule

// File: tb/tb_mc_conflict_batcher.sv
// Directed-vector bench for mc_conflict_batcher (default build, WAR blocks admission).
module tb_mc_conflict_batcher;

    localparam int NC = 4;
    localparam int MD = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NC-1:0]     s_valid, s_ready;
    logic [64*NC-1:0]  s_prog;
    logic [MD*NC-1:0]  s_rd, s_wr;
    logic              m_tvalid, m_tready;
    logic [63:0]       m_prog;
    logic [MD-1:0]     m_rd, m_wr;
    logic [7:0]        m_bid;
    logic [1:0]        m_src;
    logic              batch_completed;
    logic [31:0]       raw_c, waw_c, war_c, txn_c, closed_c;
    logic [3:0]        occ;

    typedef struct {
        logic [63:0] prog;
        logic [7:0]  bid;
        logic [1:0]  src;
    } rec_t;

    rec_t out_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    mc_conflict_batcher dut (
        .clk                             (clk),
        .rst_n                           (rst_n),
        .s_axis_tvalid                   (s_valid),
        .s_axis_tready                   (s_ready),
        .s_axis_tdata_owner_programID    (s_prog),
        .s_axis_tdata_read_dependencies  (s_rd),
        .s_axis_tdata_write_dependencies (s_wr),
        .m_axis_tvalid                   (m_tvalid),
        .m_axis_tready                   (m_tready),
        .m_axis_tdata_owner_programID    (m_prog),
        .m_axis_tdata_read_dependencies  (m_rd),
        .m_axis_tdata_write_dependencies (m_wr),
        .m_axis_tdata_batch_id           (m_bid),
        .m_axis_tdata_src_channel        (m_src),
        .batch_completed                 (batch_completed),
        .raw_conflicts                   (raw_c),
        .waw_conflicts                   (waw_c),
        .war_conflicts                   (war_c),
        .transactions_batched            (txn_c),
        .batches_closed                  (closed_c),
        .fifo_occupancy                  (occ)
    );

    always #5 clk = ~clk;

    // Record every entry that leaves the FIFO.
    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) out_q.push_back('{m_prog, m_bid, m_src});
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [63:0] prog, input int rd_bit, input int wr_bit);
        logic [MD-1:0] rd_v, wr_v;
        rd_v = '0;
        wr_v = '0;
        if (rd_bit >= 0) rd_v[rd_bit] = 1'b1;
        if (wr_bit >= 0) wr_v[wr_bit] = 1'b1;
        s_prog[ch*64 +: 64] = prog;
        s_rd[ch*MD +: MD]   = rd_v;
        s_wr[ch*MD +: MD]   = wr_v;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        s_valid  = '0;
        s_prog   = '0;
        s_rd     = '0;
        s_wr     = '0;
        m_tready = 1'b1;
        out_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (m_tvalid && n < 50) begin
            tick();
            n++;
        end
        check_eq(tag, m_tvalid, 1'b0);
    endtask

    task automatic wait_ready(input int ch, input string tag);
        int n;
        n = 0;
        while (!s_ready[ch] && n < 50) begin
            tick();
            n++;
        end
        check_eq(tag, s_ready[ch], 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        s_valid  = '0;
        s_prog   = '0;
        s_rd     = '0;
        s_wr     = '0;
        m_tready = 1'b1;
        #2;
        check_eq("rst_tvalid", m_tvalid, 1'b0);
        check_eq("rst_ready", s_ready, 4'b0000);
        check_eq("rst_occ", occ, 4'd0);
        check_eq("rst_done", batch_completed, 1'b0);
        check_eq("rst_counters", {raw_c | waw_c | war_c, txn_c | closed_c}, 64'd0);
        check_eq("rst_head", {m_prog[31:0], 22'd0, m_src, m_bid}, 64'd0);

        // Two disjoint channels land in batch 0 on consecutive cycles.
        do_reset();
        set_ch(0, 64'h100, 0, 1);
        set_ch(1, 64'h101, 2, 3);
        s_valid = 4'b0011;
        #1;
        check_eq("t1_ready_ch0", s_ready, 4'b0001);
        tick();
        s_valid[0] = 1'b0;
        #1;
        check_eq("t1_latency", m_tvalid, 1'b1);
        check_eq("t1_ready_ch1", s_ready, 4'b0010);
        tick();
        s_valid[1] = 1'b0;
        drain("t1_drain");
        check_eq("t1_count", out_q.size(), 2);
        check_eq("t1_e0", {out_q[0].prog[31:0], 14'd0, out_q[0].src, 8'd0, out_q[0].bid}, {32'h100, 32'd0});
        check_eq("t1_e1", {out_q[1].prog[31:0], 14'd0, out_q[1].src, 8'd0, out_q[1].bid}, {32'h101, 14'd0, 2'd1, 16'd0});
        check_eq("t1_txn", txn_c, 32'd2);

        // RAW against the open batch closes it; the blocked transaction opens batch 1.
        set_ch(2, 64'h102, 1, -1);
        s_valid[2] = 1'b1;
        #1;
        check_eq("t2_blocked", s_ready, 4'b0000);
        tick();
        check_eq("t2_done", batch_completed, 1'b1);
        check_eq("t2_raw", raw_c, 32'd1);
        check_eq("t2_waw_war", {waw_c, war_c}, 64'd0);
        check_eq("t2_close_ready", s_ready, 4'b0000);
        tick();
        check_eq("t2_closed", closed_c, 32'd1);
        check_eq("t2_ready_ch2", s_ready, 4'b0100);
        tick();
        s_valid[2] = 1'b0;

        // Same transaction now idles: timeout close BATCH_TIMEOUT_CYCLES+1 cycles after accept.
        n = 1;
        while (!batch_completed && n < 300) begin
            tick();
            n++;
        end
        check_eq("t4_timeout_cycles", n, 101);
        tick();
        check_eq("t4_pulse_width", batch_completed, 1'b0);
        check_eq("t4_closed", closed_c, 32'd2);
        check_eq("t2_count", out_q.size(), 3);
        check_eq("t2_e2", {out_q[2].prog[31:0], 14'd0, out_q[2].src, 8'd0, out_q[2].bid}, {32'h102, 14'd0, 2'd2, 8'd0, 8'd1});

        // WAW and WAR asserted together both count.
        do_reset();
        set_ch(0, 64'h110, 0, 4);
        s_valid = 4'b0001;
        #1;
        wait_ready(0, "t2b_ready");
        tick();
        s_valid = 4'b0000;
        s_wr[1*MD +: MD] = 256'h11;
        s_valid[1] = 1'b1;
        #1;
        check_eq("t2b_blocked", s_ready, 4'b0000);
        tick();
        check_eq("t2b_counts", {raw_c[15:0], waw_c[15:0], war_c[15:0], 15'd0, batch_completed}, {16'd0, 16'd1, 16'd1, 16'd1});
        s_valid = 4'b0000;

        // Size limit: nine disjoint transactions from channel 3.
        do_reset();
        s_valid = 4'b1000;
        for (int i = 0; i < 9; i++) begin
            set_ch(3, 64'h200 + 64'(i), 2 * i, 2 * i + 1);
            #1;
            wait_ready(3, $sformatf("t3_ready%0d", i));
            tick();
        end
        s_valid = 4'b0000;
        check_eq("t3_closed", closed_c, 32'd1);
        check_eq("t3_txn", txn_c, 32'd9);
        drain("t3_drain");
        check_eq("t3_count", out_q.size(), 9);
        for (int i = 0; i < 9; i++) begin
            check_eq($sformatf("t3_e%0d", i), {out_q[i].prog[31:0], 14'd0, out_q[i].src, 8'd0, out_q[i].bid},
                     {32'h200 + 32'(i), 14'd0, 2'd3, 8'd0, (i < 8) ? 8'd0 : 8'd1});
        end

        // Backpressure fills the FIFO, then round-robin order resumes on release.
        do_reset();
        m_tready = 1'b0;
        for (int c = 0; c < NC; c++) set_ch(c, 64'h300 + 64'(c), c + 8, -1);
        s_valid = 4'b1111;
        repeat (20) tick();
        check_eq("t5_occ_full", occ, 4'd8);
        check_eq("t5_no_ready", s_ready, 4'b0000);
        check_eq("t5_tvalid", m_tvalid, 1'b1);
        check_eq("t5_closed", closed_c, 32'd1);
        m_tready = 1'b1;
        repeat (6) tick();
        s_valid = 4'b0000;
        drain("t5_drain");
        check_eq("t5_count", out_q.size(), 14);
        for (int i = 0; i < 14; i++) begin
            check_eq($sformatf("t5_e%0d", i), {out_q[i].prog[31:0], 14'd0, out_q[i].src, 8'd0, out_q[i].bid},
                     {32'h300 + 32'(i % 4), 14'd0, 2'(i % 4), 8'd0, (i < 8) ? 8'd0 : 8'd1});
        end

        // Reset with entries in flight discards everything at once.
        do_reset();
        m_tready = 1'b0;
        for (int c = 0; c < 3; c++) set_ch(c, 64'h400 + 64'(c), c + 20, -1);
        s_valid = 4'b0111;
        repeat (3) tick();
        s_valid = 4'b0000;
        #1;
        check_eq("t6_occ3", occ, 4'd3);
        rst_n = 1'b0;
        #1;
        check_eq("t6_tvalid", m_tvalid, 1'b0);
        check_eq("t6_occ", occ, 4'd0);
        check_eq("t6_counters", {txn_c | closed_c, raw_c | waw_c | war_c}, 64'd0);
        do_reset();
        tick();
        check_eq("t6_after", m_tvalid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
